// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 14
);

   // Fetch port
   logic                  fe_req;
   logic [31:0]           fe_addr;
   logic                  fe_ack;
   logic [31:0]           fe_data;

   // Data port
   logic                  mem_req;
   logic [31:0]           mem_addr;
   logic                  mem_write;
   logic [31:0]           mem_data_in;
   logic                  mem_extend;
   logic [1:0]            mem_width;
   logic                  mem_ack;
   logic [31:0]           mem_data_out;
   logic                  mem_misalign;

   // RAM port
   logic                  ram_en;
   logic [3:0]            ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [31:0]           ram_wdata;
   logic [31:0]           ram_rdata;

   modport slave (
      input  fe_req,
      input  fe_addr,
      output fe_ack,
      output fe_data,
      input  mem_req,
      input  mem_addr,
      input  mem_write,
      input  mem_data_in,
      input  mem_extend,
      input  mem_width,
      output mem_ack,
      output mem_data_out,
      output mem_misalign,
      output ram_en,
      output ram_we,
      output ram_addr,
      output ram_wdata,
      input  ram_rdata
   );

   modport master (
      output fe_req,
      output fe_addr,
      input  fe_ack,
      input  fe_data,
      output mem_req,
      output mem_addr,
      output mem_write,
      output mem_data_in,
      output mem_extend,
      output mem_width,
      input  mem_ack,
      input  mem_data_out,
      input  mem_misalign,
      input  ram_en,
      input  ram_we,
      input  ram_addr,
      input  ram_wdata,
      output ram_rdata
   );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin front end for a single-port synchronous RAM.
// Serves instruction fetches and byte/half/word data loads and stores with one access in
// flight: grant in cycle N, ack in cycle N+1. Only the FSM state and the round-robin
// pointer are registered; requesters hold their inputs stable until ack, so the ack-cycle
// formatting is computed straight from the live request inputs.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 14
) (
   input logic          clk,
   input logic          reset_n,
   mem_arbiter_if.slave bus
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StFeWait  = 2'd1;
   localparam logic [1:0] StMemWait = 2'd2;

   localparam logic GrantFe  = 1'b0;
   localparam logic GrantMem = 1'b1;

   logic [1:0]  r_state;
   logic [1:0]  w_next_state;
   logic        r_last_grant;
   logic        w_next_last_grant;
   logic        w_grant_fe;
   logic        w_grant_mem;

   logic [1:0]  w_off;
   logic        w_misalign;
   logic [3:0]  w_st_we;
   logic [31:0] w_st_wdata;
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;
   logic [31:0] w_ld_data;

   // Address bits outside the RAM window alias; fetch byte offset is ignored.
   logic w_unused_addr;
   assign w_unused_addr = ^{bus.fe_addr[31:ADDR_WIDTH+2], bus.fe_addr[1:0],
                            bus.mem_addr[31:ADDR_WIDTH+2]};

   assign w_off = bus.mem_addr[1:0];

   // Alignment check: bytes never misalign, reserved width behaves as word.
   always_comb begin
      w_misalign = 1'b0;
      case (bus.mem_width)
         2'd0:    w_misalign = 1'b0;
         2'd1:    w_misalign = w_off[0];
         default: w_misalign = |w_off;
      endcase
   end

   // Store lane enables and replicated write data; misaligned stores write nothing.
   always_comb begin
      w_st_we    = 4'b0000;
      w_st_wdata = bus.mem_data_in;
      case (bus.mem_width)
         2'd0: begin
            w_st_we    = 4'b0001 << w_off;
            w_st_wdata = {4{bus.mem_data_in[7:0]}};
         end
         2'd1: begin
            w_st_we    = w_off[1] ? 4'b1100 : 4'b0011;
            w_st_wdata = {2{bus.mem_data_in[15:0]}};
         end
         default: begin
            w_st_we    = 4'b1111;
            w_st_wdata = bus.mem_data_in;
         end
      endcase
      if (w_misalign) begin
         w_st_we = 4'b0000;
      end
   end

   // Load lane select and sign/zero extension from the RAM read word.
   always_comb begin
      w_ld_byte = 8'h00;
      case (w_off)
         2'd0:    w_ld_byte = bus.ram_rdata[7:0];
         2'd1:    w_ld_byte = bus.ram_rdata[15:8];
         2'd2:    w_ld_byte = bus.ram_rdata[23:16];
         default: w_ld_byte = bus.ram_rdata[31:24];
      endcase
      w_ld_half = w_off[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
      w_ld_data = bus.ram_rdata;
      case (bus.mem_width)
         2'd0:    w_ld_data = {{24{bus.mem_extend & w_ld_byte[7]}}, w_ld_byte};
         2'd1:    w_ld_data = {{16{bus.mem_extend & w_ld_half[15]}}, w_ld_half};
         default: w_ld_data = bus.ram_rdata;
      endcase
   end

   // Round-robin grant in IDLE; wait states always return to IDLE so a held request
   // cannot be re-granted in its own ack cycle. Reset gates grants so no RAM strobe
   // escapes while reset_n is low.
   always_comb begin
      w_grant_fe        = 1'b0;
      w_grant_mem       = 1'b0;
      w_next_state      = r_state;
      w_next_last_grant = r_last_grant;
      case (r_state)
         StIdle: begin
            if (reset_n) begin
               if (bus.fe_req && (!bus.mem_req || (r_last_grant == GrantMem))) begin
                  w_grant_fe        = 1'b1;
                  w_next_state      = StFeWait;
                  w_next_last_grant = GrantFe;
               end else if (bus.mem_req) begin
                  w_grant_mem       = 1'b1;
                  w_next_state      = StMemWait;
                  w_next_last_grant = GrantMem;
               end
            end
         end
         StFeWait:  w_next_state = StIdle;
         StMemWait: w_next_state = StIdle;
         default:   w_next_state = StIdle;
      endcase
   end

   // FSM state and round-robin pointer; reset favours fetch on the first contention.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= StIdle;
         r_last_grant <= GrantMem;
      end else begin
         r_state      <= w_next_state;
         r_last_grant <= w_next_last_grant;
      end
   end

   // RAM strobes in the grant cycle, acks and formatted data in the following cycle.
   always_comb begin
      bus.ram_en       = 1'b0;
      bus.ram_we       = 4'b0000;
      bus.ram_addr     = '0;
      bus.ram_wdata    = 32'h0;
      bus.fe_ack       = 1'b0;
      bus.fe_data      = 32'h0;
      bus.mem_ack      = 1'b0;
      bus.mem_data_out = 32'h0;
      bus.mem_misalign = 1'b0;

      if (w_grant_fe) begin
         bus.ram_en   = 1'b1;
         bus.ram_addr = bus.fe_addr[ADDR_WIDTH+1:2];
      end else if (w_grant_mem) begin
         bus.ram_en   = 1'b1;
         bus.ram_addr = bus.mem_addr[ADDR_WIDTH+1:2];
         if (bus.mem_write) begin
            bus.ram_we    = w_st_we;
            bus.ram_wdata = w_st_wdata;
         end
      end

      if (r_state == StFeWait) begin
         bus.fe_ack  = 1'b1;
         bus.fe_data = bus.ram_rdata;
      end

      if (r_state == StMemWait) begin
         bus.mem_ack      = 1'b1;
         bus.mem_misalign = w_misalign;
         if (!bus.mem_write && !w_misalign) begin
            bus.mem_data_out = w_ld_data;
         end
      end
   end

   // Never ack both ports at once, and never strobe the RAM while an ack is pending.
   a_single_ack : assert property (@(posedge clk) disable iff (!reset_n)
                                   !(bus.fe_ack && bus.mem_ack));
   a_no_en_in_wait : assert property (@(posedge clk) disable iff (!reset_n)
                                      (r_state != StIdle) |-> !bus.ram_en);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM model, scoreboard queues for acks, table of
// data-port vectors, and hand-written sequences for latency, contention and reset.
module tb_mem_arbiter;

   localparam int unsigned AW = 14;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

   mem_arbiter #(.ADDR_WIDTH(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // RAM model with a preload side port
   logic [31:0]   ram [0:(1<<AW)-1];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [31:0]   pl_data = 32'h0;

   initial bus.ram_rdata = 32'h0;

   always @(posedge clk) begin
      if (pl_en) ram[pl_addr] <= pl_data;
      if (bus.ram_en) begin
         bus.ram_rdata <= ram[bus.ram_addr];
         for (int i = 0; i < 4; i++) begin
            if (bus.ram_we[i]) ram[bus.ram_addr][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
         end
      end
   end

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
   endtask

   // Scoreboard
   typedef struct {
      logic [31:0] data;
      logic        mis;
   } mem_exp_t;

   logic [31:0] fe_q [$];
   mem_exp_t    mem_q [$];
   bit          ack_order [$];
   int          fe_ack_cyc = 0;
   int          mem_ack_cyc = 0;
   logic [3:0]  last_we = 4'h0;
   logic [31:0] last_wdata = 32'h0;
   logic [AW-1:0] last_addr = '0;
   logic [31:0] mon_fe_e;
   mem_exp_t    mon_mem_e;

   always @(negedge clk) begin
      if (bus.fe_ack) begin
         ack_order.push_back(1'b1);
         fe_ack_cyc = cyc;
         if (fe_q.size() == 0) check("fe_ack_unexpected", {31'h0, bus.fe_ack}, 32'h0);
         else begin
            mon_fe_e = fe_q.pop_front();
            check("fe_data", bus.fe_data, mon_fe_e);
         end
      end else begin
         check("fe_data_idle", bus.fe_data, 32'h0);
      end
      if (bus.mem_ack) begin
         ack_order.push_back(1'b0);
         mem_ack_cyc = cyc;
         if (mem_q.size() == 0) check("mem_ack_unexpected", {31'h0, bus.mem_ack}, 32'h0);
         else begin
            mon_mem_e = mem_q.pop_front();
            check("mem_data_out", bus.mem_data_out, mon_mem_e.data);
            check("mem_misalign", {31'h0, bus.mem_misalign}, {31'h0, mon_mem_e.mis});
         end
      end else begin
         check("mem_idle", {bus.mem_data_out[31:1], bus.mem_data_out[0] | bus.mem_misalign},
               32'h0);
      end
      if (bus.ram_en) begin
         last_we    = bus.ram_we;
         last_wdata = bus.ram_wdata;
         last_addr  = bus.ram_addr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      pl_en = 1'b1;
      pl_addr = a;
      pl_data = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic apply_reset();
      bus.fe_req  = 1'b0;
      bus.mem_req = 1'b0;
      reset_n = 1'b0;
      tick();
      tick();
      fe_q.delete();
      mem_q.delete();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic fe_txn(input logic [31:0] addr, input logic [31:0] exp);
      bit done = 1'b0;
      fe_q.push_back(exp);
      bus.fe_addr = addr;
      bus.fe_req  = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (bus.fe_ack) done = 1'b1;
      end
      if (!done) check("fe_timeout", {31'h0, done}, 32'h1);
      tick();
      bus.fe_req = 1'b0;
   endtask

   task automatic mem_txn(input logic [31:0] addr, input logic wr, input logic [31:0] d,
                          input logic ext, input logic [1:0] w, input logic [31:0] exp,
                          input logic mis);
      bit done = 1'b0;
      mem_q.push_back('{data: exp, mis: mis});
      bus.mem_addr    = addr;
      bus.mem_write   = wr;
      bus.mem_data_in = d;
      bus.mem_extend  = ext;
      bus.mem_width   = w;
      bus.mem_req     = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (bus.mem_ack) done = 1'b1;
      end
      if (!done) check("mem_timeout", {31'h0, done}, 32'h1);
      tick();
      bus.mem_req = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] d;
      logic        ext;
      logic [1:0]  w;
      logic [31:0] exp;
      logic        mis;
      logic [3:0]  we;
      logic [31:0] wdata;
   } vec_t;

   vec_t vecs [$];

   task automatic add_vec(input string n, input logic [31:0] a, input logic wr,
                          input logic [31:0] d, input logic ext, input logic [1:0] w,
                          input logic [31:0] exp, input logic mis, input logic [3:0] we,
                          input logic [31:0] wdata);
      vec_t v;
      v.name = n; v.addr = a; v.wr = wr; v.d = d; v.ext = ext; v.w = w;
      v.exp = exp; v.mis = mis; v.we = we; v.wdata = wdata;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      bus.fe_req = 1'b0;      bus.fe_addr = 32'h0;
      bus.mem_req = 1'b0;     bus.mem_addr = 32'h0;    bus.mem_write = 1'b0;
      bus.mem_data_in = 32'h0; bus.mem_extend = 1'b0;   bus.mem_width = 2'd0;

      // Reset state, with both requests pending while reset is held
      tick();
      bus.fe_req = 1'b1;
      bus.mem_req = 1'b1;
      @(negedge clk);
      check("rst_ram_en", {31'h0, bus.ram_en}, 32'h0);
      check("rst_ram_we", {28'h0, bus.ram_we}, 32'h0);
      check("rst_acks", {30'h0, bus.fe_ack, bus.mem_ack}, 32'h0);
      bus.fe_req = 1'b0;
      bus.mem_req = 1'b0;
      reset_n = 1'b1;
      tick();
      @(negedge clk);
      check("idle_ram_en", {31'h0, bus.ram_en}, 32'h0);
      tick();

      preload(14'h0004, 32'h0050_0093);
      preload(14'h0000, 32'h0000_F080);
      preload(14'h0040, 32'h1122_3344);
      preload(14'h0080, 32'hCAFE_BABE);

      // Single fetch: strobe in cycle 0, ack with data in cycle 1
      apply_reset();
      fe_q.push_back(32'h0050_0093);
      bus.fe_addr = 32'h0000_0010;
      bus.fe_req = 1'b1;
      @(negedge clk);
      check("t1_ram_en", {31'h0, bus.ram_en}, 32'h1);
      check("t1_ram_addr", {18'h0, bus.ram_addr}, 32'h4);
      check("t1_ram_we", {28'h0, bus.ram_we}, 32'h0);
      check("t1_no_early_ack", {31'h0, bus.fe_ack}, 32'h0);
      @(negedge clk);
      check("t1_fe_ack", {31'h0, bus.fe_ack}, 32'h1);
      check("t1_ram_en_off", {31'h0, bus.ram_en}, 32'h0);
      tick();
      bus.fe_req = 1'b0;

      // First contention after reset: fetch first, data two cycles later
      apply_reset();
      t0 = cyc;
      fork
         fe_txn(32'h0000_0010, 32'h0050_0093);
         mem_txn(32'h0000_0010, 1'b0, 32'h0, 1'b0, 2'd2, 32'h0050_0093, 1'b0);
      join
      check("t2_fe_lat", 32'(fe_ack_cyc - t0), 32'd1);
      check("t2_mem_lat", 32'(mem_ack_cyc - t0), 32'd3);

      // Held requests alternate
      ack_order.delete();
      fork
         for (int i = 0; i < 3; i++) fe_txn(32'h0000_0010, 32'h0050_0093);
         for (int i = 0; i < 3; i++)
            mem_txn(32'h0000_0000, 1'b0, 32'h0, 1'b0, 2'd2, 32'h0000_F080, 1'b0);
      join
      check("t2_order_len", 32'(ack_order.size()), 32'd6);
      for (int i = 0; i < ack_order.size(); i++) begin
         check($sformatf("t2_order_%0d", i), {31'h0, ack_order[i]}, {31'h0, ((i % 2) == 0)});
      end

      // Data-port vectors, applied in order (stores affect later loads)
      add_vec("lb",       32'h000, 0, 32'h0, 1, 2'd0, 32'hFFFF_FF80, 0, 4'h0, 32'h0);
      add_vec("lbu",      32'h000, 0, 32'h0, 0, 2'd0, 32'h0000_0080, 0, 4'h0, 32'h0);
      add_vec("lh",       32'h000, 0, 32'h0, 1, 2'd1, 32'hFFFF_F080, 0, 4'h0, 32'h0);
      add_vec("lhu_2",    32'h002, 0, 32'h0, 0, 2'd1, 32'h0000_0000, 0, 4'h0, 32'h0);
      add_vec("lb_1",     32'h001, 0, 32'h0, 1, 2'd0, 32'hFFFF_FFF0, 0, 4'h0, 32'h0);
      add_vec("lw",       32'h000, 0, 32'h0, 1, 2'd2, 32'h0000_F080, 0, 4'h0, 32'h0);
      add_vec("lw_rsv",   32'h000, 0, 32'h0, 0, 2'd3, 32'h0000_F080, 0, 4'h0, 32'h0);
      add_vec("sb_103",   32'h103, 1, 32'h0000_00AB, 0, 2'd0, 32'h0, 0, 4'b1000, 32'hABAB_ABAB);
      add_vec("lw_100",   32'h100, 0, 32'h0, 0, 2'd2, 32'hAB22_3344, 0, 4'h0, 32'h0);
      add_vec("sh_102",   32'h102, 1, 32'hFFFF_1234, 0, 2'd1, 32'h0, 0, 4'b1100, 32'h1234_1234);
      add_vec("lw_alias", 32'h0001_0100, 0, 32'h0, 0, 2'd2, 32'h1234_3344, 0, 4'h0, 32'h0);
      add_vec("lbu_103",  32'h103, 0, 32'h0, 0, 2'd0, 32'h0000_0012, 0, 4'h0, 32'h0);
      add_vec("sw_104",   32'h104, 1, 32'hDEAD_BEEF, 0, 2'd2, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF);
      add_vec("lh_106",   32'h106, 0, 32'h0, 1, 2'd1, 32'hFFFF_DEAD, 0, 4'h0, 32'h0);
      add_vec("sb_101",   32'h101, 1, 32'h0000_0077, 0, 2'd0, 32'h0, 0, 4'b0010, 32'h7777_7777);
      add_vec("lw_100b",  32'h100, 0, 32'h0, 0, 2'd2, 32'h1234_7744, 0, 4'h0, 32'h0);
      add_vec("sh_mis",   32'h201, 1, 32'h0000_5555, 0, 2'd1, 32'h0, 1, 4'h0, 32'h0);
      add_vec("lw_200",   32'h200, 0, 32'h0, 0, 2'd2, 32'hCAFE_BABE, 0, 4'h0, 32'h0);
      add_vec("lw_mis",   32'h202, 0, 32'h0, 0, 2'd2, 32'h0, 1, 4'h0, 32'h0);
      add_vec("lh_mis",   32'h203, 0, 32'h0, 1, 2'd1, 32'h0, 1, 4'h0, 32'h0);
      add_vec("sw_mis",   32'h201, 1, 32'h1111_1111, 0, 2'd2, 32'h0, 1, 4'h0, 32'h0);
      add_vec("lb_203",   32'h203, 0, 32'h0, 1, 2'd0, 32'hFFFF_FFCA, 0, 4'h0, 32'h0);
      add_vec("lbu_202",  32'h202, 0, 32'h0, 0, 2'd0, 32'h0000_00FE, 0, 4'h0, 32'h0);

      foreach (vecs[i]) begin
         mem_txn(vecs[i].addr, vecs[i].wr, vecs[i].d, vecs[i].ext, vecs[i].w,
                 vecs[i].exp, vecs[i].mis);
         check({vecs[i].name, "_we"}, {28'h0, last_we}, {28'h0, vecs[i].we});
         check({vecs[i].name, "_addr"}, {18'h0, last_addr}, {18'h0, vecs[i].addr[AW+1:2]});
         if (vecs[i].we != 4'h0) check({vecs[i].name, "_wdata"}, last_wdata, vecs[i].wdata);
      end
      check("mis_ram_unchanged", ram[14'h0080], 32'hCAFE_BABE);

      // Reset in the cycle after a load grant drops the ack
      apply_reset();
      bus.mem_addr = 32'h0000_0010;
      bus.mem_write = 1'b0;
      bus.mem_width = 2'd2;
      bus.mem_req = 1'b1;
      @(negedge clk);
      check("t6_grant", {31'h0, bus.ram_en}, 32'h1);
      tick();
      reset_n = 1'b0;
      @(negedge clk);
      check("t6_no_ack", {31'h0, bus.mem_ack}, 32'h0);
      check("t6_ram_en", {31'h0, bus.ram_en}, 32'h0);
      bus.mem_req = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      t0 = cyc;
      fe_txn(32'h0000_0010, 32'h0050_0093);
      check("t6_fe_after", 32'(fe_ack_cyc - t0), 32'd1);

      repeat (3) tick();
      check("fe_q_drained", 32'(fe_q.size()), 32'd0);
      check("mem_q_drained", 32'(mem_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
